// File: rtl/expr_eval.sv
// expr_eval: streaming digit((+|*)digit)* evaluator with '*' precedence; define EXPR_EVAL_OVF_EN for sticky overflow detection
module expr_eval #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             legal,
  output logic             err,
  output logic             ovf
);
  typedef enum logic [1:0] {START, AFTER_DIGIT, AFTER_OP, ERROR} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sum, term, d, t_mul, t_nxt, sum_add;
  logic mul_pend, is_dig, is_op, dig_ok;
`ifdef EXPR_EVAL_OVF_EN
  logic [WIDTH+3:0] prod;
  logic [WIDTH:0] add;
  assign prod = {4'b0, term} * {{WIDTH{1'b0}}, in[3:0]};
  assign add = {1'b0, sum} + {1'b0, term};
  assign t_mul = prod[WIDTH-1:0];
  assign sum_add = add[WIDTH-1:0];
  always_ff @(posedge clk)
    if (!clr) ovf <= 1'b0;
    else if ((dig_ok && mul_pend && |prod[WIDTH+3:WIDTH]) || (in_valid && state == AFTER_DIGIT && in == 8'h2b && add[WIDTH])) ovf <= 1'b1;
`else
  assign t_mul = term * d;
  assign sum_add = sum + term;
  assign ovf = 1'b0;
`endif
  always_comb begin
    is_dig = in >= 8'h30 && in <= 8'h39;
    is_op = in == 8'h2b || in == 8'h2a;
    d = WIDTH'(in[3:0]);
    t_nxt = mul_pend ? t_mul : d;
    dig_ok = in_valid && is_dig && (state == START || state == AFTER_OP);
    state_n = !in_valid || state == ERROR ? state :
              state == AFTER_DIGIT ? (is_op ? AFTER_OP : ERROR) :
              is_dig ? AFTER_DIGIT : ERROR;
  end
  always_ff @(posedge clk)
    if (!clr) begin
      state <= START;
      sum <= '0;
      term <= '0;
      mul_pend <= 1'b0;
      result <= '0;
      res_valid <= 1'b0;
    end else begin
      state <= state_n;
      res_valid <= dig_ok;
      if (dig_ok) begin
        term <= t_nxt;
        result <= (state == START ? '0 : sum) + t_nxt;
      end
      if (dig_ok && state == START) sum <= '0;
      if (in_valid && state == AFTER_DIGIT && is_op) begin
        mul_pend <= in == 8'h2a;
        if (in == 8'h2b) sum <= sum_add;
      end
    end
  assign legal = state == AFTER_DIGIT;
  assign err = state == ERROR;
endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream consumer of the ASCII expression recogniser; runs in parallel on the same character stream.
- Accepts one ASCII character per accepted cycle.
- Evaluates expressions of the form digit((+|*)digit)* with standard precedence ('*' binds tighter than '+').
- Presents the running value of the expression parsed so far, plus legality/error status, for display or comparison logic.

Parameters:
- WIDTH, 32, bit width of the sum, term and result datapath; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, synchronous, active-low; priority over all other inputs.
- in  input  8  ASCII character.
- in_valid  input  1  character on `in` is consumed this cycle when high; all state holds when low.
- result  output  WIDTH  value of the expression parsed so far; valid when legal=1.
- res_valid  output  1  one-cycle pulse: result updated by a digit accepted in the previous cycle.
- legal  output  1  stream so far is a complete legal expression (ends in a digit).
- err  output  1  sticky: illegal character sequence seen since last reset.
- ovf  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (clr=0 at a clk edge), all registers and outputs go to 0:
  - state=START, sum=0, term=0, mul_pend=0, result=0, res_valid=0, legal=0, err=0, ovf=0.
- Reset mid-expression discards all partial results. The first accepted character after clr returns high is treated as the start of a new expression.
- Digit: '0'..'9' (0x30..0x39), d = in - 0x30 zero-extended to WIDTH. Operator: '+' (0x2B) or '*' (0x2A). Every other byte is illegal.
- FSM states are START, AFTER_DIGIT, AFTER_OP, ERROR. All transitions happen only on cycles with in_valid=1.
  - START: digit -> term<=d, sum<=0, AFTER_DIGIT. Anything else -> ERROR.
  - AFTER_DIGIT: '+' -> sum<=sum+term, mul_pend<=0, AFTER_OP. '*' -> mul_pend<=1, AFTER_OP. Anything else (including a digit) -> ERROR.
  - AFTER_OP, on a digit:
    - t' = mul_pend ? term*d : d (low WIDTH bits).
    - term<=t'; go to AFTER_DIGIT.
  - AFTER_OP, on anything else -> ERROR.
  - ERROR: absorbing until reset; err=1; result is held at its last value.
- On every accepted digit that does not cause an error:
  - result <= sum + t' (START case: result <= d).
  - res_valid=1 on the next cycle only. Latency from accepted digit to result update is 1 cycle.
- legal is registered: 1 exactly when state=AFTER_DIGIT.
- res_valid is 0 whenever in_valid was 0 in the previous cycle. It is never 1 in ERROR.
- Single-digit expressions are legal; "7" gives result=7.
- Multiplication by 0 is legal; the term becomes 0 and subsequent '*' operands keep it 0.

Optional Feature:
- Macro: EXPR_EVAL_OVF_EN.
- Defined:
  - ovf is set when any sum+term addition or term*d multiplication produces a true result ≥ 2^WIDTH. Checked with a (WIDTH+4)-bit product and a WIDTH+1-bit sum.
  - ovf is sticky until clr; evaluation continues with the wrapped value.
- Undefined: the ovf port exists but is tied to 0, and no overflow logic is synthesised.

Test Plan:
- clr pulse, then "1+2*3" with in_valid=1 every cycle -> result=7 and legal=1 one cycle after '3'; res_valid pulses after '1', '2' and '3' with result 1, 3, 7.
- "2*3*4+5" -> final result=29. Intermediate results after each digit: 2, 6, 24, 29.
- "1++2" -> err=1 and legal=0 from the cycle after the second '+'; result stays 1; feeding '2' changes nothing. A clr pulse then "4" gives result=4 and err=0.
- "3+4" with in_valid low for 3 cycles between '+' and '4' -> no state change during the gap; result=7 one cycle after '4' is accepted; legal=0 throughout the gap.
- WIDTH=8, "9*9*9" -> result=217 (729 mod 256). With EXPR_EVAL_OVF_EN defined, ovf=1 after the third '9'; without the macro, ovf=0.
- "5*6" with clr low in the cycle '*' is presented -> all outputs 0. A following "8" gives result=8, legal=1.
